// File: rtl/seq_pattern_tx.sv
// Serializes a latched WIDTH-bit pattern MSB first, repeating it repeat_n+1 times with gap idle cycles between frames.
// All outputs are registered. The first bit appears one cycle after start is accepted.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP_W = 4,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             data_out,
  output logic             valid,
  output logic             busy,
  output logic             last_bit,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [RPT_W-1:0] frm_q, frm_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             last_bit_q, last_bit_d;
  logic             done_q, done_d;

  // state_q describes what the output registers are currently presenting.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    frm_d   = frm_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_d   = pattern;
            frm_d   = repeat_n;
            gap_d   = gap;
            idx_d   = IDX_TOP;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (frm_q == '0) begin
            state_d = DONE;
          end else begin
            frm_d = frm_q - 1'b1;
            if (gap_q != '0) begin
              gcnt_d  = gap_q;
              state_d = GAP;
            end else begin
              idx_d = IDX_TOP;
            end
          end
        end
        GAP: begin
          // gcnt_q holds the gap cycles remaining including the current one.
          if (gcnt_q == GAP_W'(1)) begin
            gcnt_d  = '0;
            idx_d   = IDX_TOP;
            state_d = SHIFT;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered images of the next state, so no input reaches a pin combinationally.
    data_out_d = (state_d == SHIFT) && pat_d[idx_d];
    valid_d    = (state_d == SHIFT);
    busy_d     = (state_d == SHIFT) || (state_d == GAP);
    last_bit_d = (state_d == SHIFT) && (idx_d == '0) && (frm_d == '0);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      frm_q      <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      idx_q      <= '0;
      data_out_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      last_bit_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      frm_q      <= frm_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      last_bit_q <= last_bit_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign last_bit = last_bit_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: bursts, gap/no-gap framing, ignored restart, abort and mid-gap reset.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] repeat_n = '0;
  logic [3:0] gap = '0;
  logic       abort = 1'b0;
  logic       data_out, valid, busy, last_bit, done;

  int checks = 0;
  int failures = 0;

  seq_pattern_tx #(.WIDTH(8), .GAP_W(4), .RPT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap      (gap),
    .abort    (abort),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy),
    .last_bit (last_bit),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_dat"}, 32'(data_out), 0);
    chk({tag, "_vld"}, 32'(valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_last"}, 32'(last_bit), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Starts a burst and checks every cycle through the done pulse; returns the serial bits seen.
  task automatic run_burst(input logic [7:0] pat, input logic [3:0] rpt, input logic [3:0] g,
                           output logic [63:0] got);
    int busy_cnt;
    busy_cnt = 0;
    got = '0;
    pattern = pat; repeat_n = rpt; gap = g; start = 1'b1;
    tick();
    start = 1'b0; pattern = ~pat; repeat_n = 4'd0; gap = 4'd0;
    for (int f = 0; f <= int'(rpt); f++) begin
      for (int b = 7; b >= 0; b--) begin
        chk("bit_vld", 32'(valid), 1);
        chk("bit_dat", 32'(data_out), 32'(pat[b]));
        chk("bit_last", 32'(last_bit), 32'((f == int'(rpt)) && (b == 0)));
        got = {got[62:0], data_out};
        busy_cnt += int'(busy);
        tick();
      end
      if (f < int'(rpt)) begin
        for (int k = 0; k < int'(g); k++) begin
          chk("gap_vld", 32'(valid), 0);
          chk("gap_dat", 32'(data_out), 0);
          chk("gap_done", 32'(done), 0);
          busy_cnt += int'(busy);
          tick();
        end
      end
    end
    chk("busy_total", 32'(busy_cnt), 32'((int'(rpt) + 1) * 8 + int'(rpt) * int'(g)));
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_vld", 32'(valid), 0);
    tick();
    chk("after_done", 32'(done), 0);
    chk("after_busy", 32'(busy), 0);
  endtask

  logic [63:0] got;
  int          done_cnt;
  int          vld_cnt;

  initial begin
    #3;
    chk_quiet("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    // Hand-computed serial streams.
    run_burst(8'b11101000, 4'd0, 4'd0, got);
    chk("p031_bits", 32'(got[7:0]), 32'h000000E8);
    run_burst(8'hA5, 4'd2, 4'd3, got);
    chk("p032_bits", got[23:0], 32'h00A5A5A5);
    run_burst(8'hE8, 4'd1, 4'd0, got);
    chk("p033_bits", 32'(got[15:0]), 32'h0000E8E8);
    run_burst(8'h3C, 4'd1, 4'd1, got);
    chk("gap1_bits", 32'(got[15:0]), 32'h00003C3C);
    run_burst(8'h5A, 4'd15, 4'd15, got);
    chk("max_bits", got[31:0], 32'h5A5A5A5A);

    // Restart attempt during a frame must not disturb it.
    pattern = 8'hFF; repeat_n = 4'd0; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    got = '0;
    for (int b = 0; b < 8; b++) begin
      got = {got[62:0], data_out};
      if (b == 2) begin start = 1'b1; pattern = 8'h00; end
      if (b == 5) start = 1'b0;
      tick();
    end
    chk("p034_bits", 32'(got[7:0]), 32'h000000FF);
    for (int c = 0; c < 6; c++) begin
      done_cnt += int'(done);
      tick();
    end
    chk("p034_done_cnt", 32'(done_cnt), 1);
    chk("p034_idle_vld", 32'(valid), 0);

    // Abort on the 4th bit of the first of three frames.
    pattern = 8'hA5; repeat_n = 4'd2; gap = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("p035_bit4_vld", 32'(valid), 1);
    chk("p035_bit4_dat", 32'(data_out), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("p035_abort");
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      done_cnt += int'(done) + int'(valid);
      tick();
    end
    chk("p035_silent", 32'(done_cnt), 0);
    run_burst(8'hC3, 4'd0, 4'd0, got);
    chk("p035_new_bits", 32'(got[7:0]), 32'h000000C3);

    // Abort beats start in the same cycle.
    pattern = 8'hFF; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_prio_vld", 32'(valid), 0);
    chk("abort_prio_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of a gap.
    pattern = 8'h81; repeat_n = 4'd3; gap = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 9; b++) tick();
    chk("p036_in_gap_busy", 32'(busy), 1);
    chk("p036_in_gap_vld", 32'(valid), 0);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("p036_async");
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    vld_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      done_cnt += int'(done);
      vld_cnt += int'(valid) + int'(busy);
      tick();
    end
    chk("p036_no_done", 32'(done_cnt), 0);
    chk("p036_no_bits", 32'(vld_cnt), 0);
    run_burst(8'h96, 4'd0, 4'd2, got);
    chk("p036_new_bits", 32'(got[7:0]), 32'h00000096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
